// File: rtl/ncc_grid_sequencer.sv
// ncc_grid_sequencer
// Sequences one job on the 16x16 log-domain NCC grid: loads the descriptor word by word
// (row / 4-PE column group), streams WIN_LEN window pixels, flushes the systolic pipeline
// for GRID-1 cycles and tags every completed correlation result with its window position.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for i_start
// S_DESC  | accepting descriptor words, row/column-group counters live
// S_WIN   | accepting window pixels, one load_win/load_acc per pixel
// S_DRAIN | flushing the pipeline, load_acc held high for GRID-1 cycles
// S_DONE  | one-cycle done pulse, back to idle

module ncc_grid_sequencer #(
    parameter int GRID    = 16,
    parameter int WIN_LEN = 640,
    localparam int ROW_W  = $clog2(GRID),
    localparam int IDX_W  = $clog2(WIN_LEN),
    localparam int ACC_W  = $clog2(WIN_LEN + GRID + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_desc_valid,
    output logic             o_desc_ready,
    output logic [ROW_W-1:0] o_desc_row,
    output logic [1:0]       o_desc_col_group,
    output logic             o_desc_load,
    input  logic             i_win_valid,
    output logic             o_win_ready,
    output logic             o_load_win,
    output logic             o_load_acc,
    output logic             o_res_valid,
    output logic [IDX_W-1:0] o_res_index,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DESC,
        S_WIN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [ROW_W-1:0]   r_row;
    logic [1:0]         r_grp;
    logic [IDX_W-1:0]   r_win_left;
    logic [ROW_W-1:0]   r_drain_left;
    logic               r_desc_ready;
    logic               r_win_ready;
    logic               r_drain_acc;
    logic               r_busy;
    logic               r_done;
    logic [ACC_W-1:0]   r_acc_cnt;
    logic               r_res_valid;
    logic [IDX_W-1:0]   r_res_index;

    logic               w_desc_load;
    logic               w_win_load;
    logic               w_load_acc;
    logic [ACC_W-1:0]   w_acc_next;

    assign w_desc_load = i_desc_valid & r_desc_ready;
    assign w_win_load  = i_win_valid & r_win_ready;
    assign w_load_acc  = w_win_load | r_drain_acc;
    assign w_acc_next  = r_acc_cnt + 1'b1;

    // Job sequencing: state, descriptor addressing, pixel and drain down-counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_grp        <= '0;
            r_win_left   <= '0;
            r_drain_left <= '0;
            r_desc_ready <= 1'b0;
            r_win_ready  <= 1'b0;
            r_drain_acc  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state      <= S_DESC;
                        r_row        <= '0;
                        r_grp        <= '0;
                        r_desc_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_DESC: begin
                    if (w_desc_load) begin
                        r_grp <= r_grp + 1'b1;
                        if (r_grp == 2'd3) begin
                            r_row <= r_row + 1'b1;
                            if (r_row == ROW_W'(GRID - 1)) begin
                                r_state      <= S_WIN;
                                r_row        <= '0;
                                r_grp        <= '0;
                                r_desc_ready <= 1'b0;
                                r_win_ready  <= 1'b1;
                                r_win_left   <= IDX_W'(WIN_LEN - 1);
                            end
                        end
                    end
                end
                S_WIN: begin
                    if (w_win_load) begin
                        if (r_win_left == '0) begin
                            r_state      <= S_DRAIN;
                            r_win_ready  <= 1'b0;
                            r_drain_acc  <= 1'b1;
                            r_drain_left <= ROW_W'(GRID - 2);
                        end else begin
                            r_win_left <= r_win_left - 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain_left == '0) begin
                        r_state     <= S_DONE;
                        r_drain_acc <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_drain_left <= r_drain_left - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_desc_ready <= 1'b0;
                    r_win_ready  <= 1'b0;
                    r_drain_acc  <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    // Result tagging: the pipeline is GRID deep, so accumulator pulse N (1-based) completes
    // window position N-GRID.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc_cnt   <= '0;
            r_res_valid <= 1'b0;
            r_res_index <= '0;
        end else begin
            r_res_valid <= 1'b0;
            if (r_state == S_IDLE && i_start) begin
                r_acc_cnt <= '0;
            end else if (w_load_acc) begin
                r_acc_cnt <= w_acc_next;
                if (w_acc_next >= ACC_W'(GRID)) begin
                    r_res_valid <= 1'b1;
                    r_res_index <= IDX_W'(w_acc_next - ACC_W'(GRID));
                end
            end
        end
    end

    assign o_desc_ready     = r_desc_ready;
    assign o_desc_row       = r_row;
    assign o_desc_col_group = r_grp;
    assign o_desc_load      = w_desc_load;
    assign o_win_ready      = r_win_ready;
    assign o_load_win       = w_win_load;
    assign o_load_acc       = w_load_acc;
    assign o_res_valid      = r_res_valid;
    assign o_res_index      = r_res_index;
    assign o_busy           = r_busy;
    assign o_done           = r_done;

endmodule
